// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: command-phase handshake bundle between the arbiter and its sub-controllers/user side
// master (arbiter): drives init/ref/wr/rd_start pulses, sel (one-hot pin owner), init_ok, busy, ref_miss
// slave (sub-controllers, user): drives init/ref/wr/rd_done pulses and wr_req/rd_req levels
interface sdram_arbiter_if;
  logic       init_start, init_done;
  logic       ref_start, ref_done;
  logic       wr_req, wr_start, wr_done;
  logic       rd_req, rd_start, rd_done;
  logic [3:0] sel;
  logic       init_ok, busy, ref_miss;
  modport master (
    output init_start, ref_start, wr_start, rd_start, sel, init_ok, busy, ref_miss,
    input  init_done, ref_done, wr_req, wr_done, rd_req, rd_done
  );
  modport slave (
    input  init_start, ref_start, wr_start, rd_start, sel, init_ok, busy, ref_miss,
    output init_done, ref_done, wr_req, wr_done, rd_req, rd_done
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: sequences SDRAM init, periodic auto-refresh and user write/read grants onto one-hot pin ownership
// ports: clk, rst (sync, active-high); bus (sdram_arbiter_if.master) carries start/done pulses, req levels,
//        sel (0001 init, 0010 write, 0100 refresh, 1000 read), init_ok, busy, ref_miss
// params: REF_PERIOD cycles between refresh requests, CNT_W refresh counter width
// option: SDRAM_ARB_REFMISS_EN enables the sticky ref_miss overrun flag; otherwise ref_miss is tied low
module sdram_arbiter #(
  parameter int REF_PERIOD = 390,
  parameter int CNT_W      = 10
) (
  input logic clk,
  input logic rst,
  sdram_arbiter_if.master bus
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REF, S_WR, S_RD} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0] r_sel, w_sel;
  logic r_ref_pend, r_init_issued, r_init_ok, r_busy;
  logic r_init_start, r_ref_start, r_wr_start, r_rd_start;
  logic w_expire, w_idle, w_grant_ref, w_grant_wr, w_grant_rd;
  assign w_expire    = r_init_ok && (r_cnt == CNT_W'(REF_PERIOD - 1));
  assign w_idle      = r_state == S_IDLE;
  assign w_grant_ref = w_idle && r_ref_pend;
  assign w_grant_wr  = w_idle && !r_ref_pend && bus.wr_req;
  assign w_grant_rd  = w_idle && !r_ref_pend && !bus.wr_req && bus.rd_req;
  // a done coinciding with its own start pulse is ignored, hence the !r_*_start terms
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  w_next = (bus.init_done && r_init_issued && !r_init_start) ? S_IDLE : S_INIT;
      S_IDLE:  w_next = w_grant_ref ? S_REF : w_grant_wr ? S_WR : w_grant_rd ? S_RD : S_IDLE;
      S_REF:   w_next = (bus.ref_done && !r_ref_start) ? S_IDLE : S_REF;
      S_WR:    w_next = (bus.wr_done && !r_wr_start) ? S_IDLE : S_WR;
      S_RD:    w_next = (bus.rd_done && !r_rd_start) ? S_IDLE : S_RD;
      default: w_next = S_INIT;
    endcase
    w_sel = w_grant_ref ? 4'b0100 : w_grant_wr ? 4'b0010 : w_grant_rd ? 4'b1000 : r_sel;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= S_INIT;
    else     r_state <= w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_sel         <= 4'b0001;
      r_ref_pend    <= 1'b0;
      r_init_issued <= 1'b0;
      r_init_ok     <= 1'b0;
      r_busy        <= 1'b1;
      r_init_start  <= 1'b0;
      r_ref_start   <= 1'b0;
      r_wr_start    <= 1'b0;
      r_rd_start    <= 1'b0;
    end else begin
      r_cnt         <= (!r_init_ok || w_expire) ? '0 : r_cnt + 1'b1;
      r_sel         <= w_sel;
      r_ref_pend    <= w_expire || (r_ref_pend && !w_grant_ref);
      r_init_issued <= 1'b1;
      r_init_ok     <= r_init_ok || (r_state == S_INIT && w_next == S_IDLE);
      r_busy        <= w_next != S_IDLE;
      r_init_start  <= r_state == S_INIT && !r_init_issued;
      r_ref_start   <= w_grant_ref;
      r_wr_start    <= w_grant_wr;
      r_rd_start    <= w_grant_rd;
    end
  end
`ifdef SDRAM_ARB_REFMISS_EN
  logic r_ref_miss;
  always_ff @(posedge clk)
    if (rst) r_ref_miss <= 1'b0;
    else     r_ref_miss <= r_ref_miss || (w_expire && r_ref_pend);
  assign bus.ref_miss = r_ref_miss;
`else
  assign bus.ref_miss = 1'b0;
`endif
  assign bus.init_start = r_init_start;
  assign bus.ref_start  = r_ref_start;
  assign bus.wr_start   = r_wr_start;
  assign bus.rd_start   = r_rd_start;
  assign bus.sel        = r_sel;
  assign bus.init_ok    = r_init_ok;
  assign bus.busy       = r_busy;
endmodule
